// File: rtl/mem_stage_param.sv
// MEM pipeline stage: byte-addressable data memory with sub-word access,
// fault detection, load-to-store forwarding and a stall-able output register.
module mem_stage_param #(
    parameter int SIZE      = 32,
    parameter int DEPTH     = 16,
    parameter int CTRL_W    = 11,
    parameter int RD_BIT    = 6,
    parameter int WR_BIT    = 8,
    parameter int TEST_ADDR = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [SIZE-1:0]   ALUresultEX,
    input  logic [SIZE-1:0]   storeDataEX,
    input  logic [4:0]        writeRegEX,
    input  logic [4:0]        rtEX,
    input  logic [CTRL_W-1:0] controlEX,
    input  logic [1:0]        accessSize,
    input  logic              loadUnsigned,
    output logic [SIZE-1:0]   data,
    output logic [SIZE-1:0]   ALUresultMEM,
    output logic [4:0]        writeRegMEM,
    output logic [CTRL_W-1:0] controlMEM,
    output logic              misaligned,
    output logic              outOfRange,
    output logic [SIZE-1:0]   testMEM
);
    localparam int NB = SIZE / 8;
    localparam int BL = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = SIZE - BL;

    logic [SIZE-1:0] mem [DEPTH];

    logic [BL-1:0]   lane;
    logic [IW-1:0]   idx;
    logic [AW-1:0]   widx;
    logic            oor;
    logic            mis;
    logic            is_rd;
    logic            is_wr;
    logic            fault;
    logic            fwd;
    logic            we;
    logic            sx;
    logic [NB-1:0]   lmask;
    logic [NB-1:0]   be;
    logic [SIZE-1:0] sdata;
    logic [SIZE-1:0] wdata;
    logic [SIZE-1:0] rword;
    logic [SIZE-1:0] rsh;
    logic [SIZE-1:0] load_val;

    assign lane = ALUresultEX[BL-1:0];
    assign idx  = ALUresultEX[SIZE-1:BL];
    assign widx = idx[AW-1:0];

    generate
        if (IW > AW) begin : g_oor
            assign oor = |idx[IW-1:AW];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
    endgenerate

    // RD+WR together is illegal and degrades to a plain store
    assign is_wr = controlEX[WR_BIT];
    assign is_rd = controlEX[RD_BIT] & ~is_wr;
    assign fault = (is_rd | is_wr) & (mis | oor);

    always_comb begin
        mis   = 1'b0;
        lmask = '1;
        unique case (accessSize)
            2'b00: begin
                mis   = 1'b0;
                lmask = NB'(1);
            end
            2'b01: begin
                mis   = lane[0];
                lmask = NB'(3);
            end
            default: begin
                mis   = |lane;
                lmask = '1;
            end
        endcase
    end

    assign fwd = controlMEM[RD_BIT] & is_wr
               & (writeRegMEM == rtEX) & (rtEX != 5'd0);
    assign sdata = fwd ? data : storeDataEX;
    assign wdata = sdata << {lane, 3'b000};
    assign be    = lmask << lane;
    assign we    = is_wr & ~fault & ~stall;

    assign rword = mem[widx];
    assign rsh   = rword >> {lane, 3'b000};
    assign sx    = ~loadUnsigned;

    always_comb begin
        unique case (accessSize)
            2'b00:   load_val = {{(SIZE-8){sx & rsh[7]}}, rsh[7:0]};
            2'b01:   load_val = {{(SIZE-16){sx & rsh[15]}}, rsh[15:0]};
            default: load_val = rword;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= SIZE'(i);
            end
        end else if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data         <= '0;
            ALUresultMEM <= '0;
            writeRegMEM  <= '0;
            controlMEM   <= '0;
            misaligned   <= 1'b0;
            outOfRange   <= 1'b0;
        end else if (!stall) begin
            ALUresultMEM <= ALUresultEX;
            writeRegMEM  <= writeRegEX;
            controlMEM   <= controlEX;
            misaligned   <= (is_rd | is_wr) & mis;
            outOfRange   <= (is_rd | is_wr) & oor;
            if (fault) begin
                data <= '0;
            end else if (is_rd) begin
                data <= load_val;
            end
        end
    end

    assign testMEM = mem[AW'(TEST_ADDR)];

endmodule

// File: tb/tb_mem_stage_param.sv
// Scoreboard bench for mem_stage_param: loads, sub-word stores,
// forwarding, faults, stall and asynchronous reset.
module tb_mem_stage_param;
    localparam logic [10:0] LD  = 11'h041;
    localparam logic [10:0] ST  = 11'h100;
    localparam logic [10:0] NOP = 11'h000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [31:0] ALUresultEX;
    logic [31:0] storeDataEX;
    logic [4:0]  writeRegEX;
    logic [4:0]  rtEX;
    logic [10:0] controlEX;
    logic [1:0]  accessSize;
    logic        loadUnsigned;
    logic [31:0] data;
    logic [31:0] ALUresultMEM;
    logic [4:0]  writeRegMEM;
    logic [10:0] controlMEM;
    logic        misaligned;
    logic        outOfRange;
    logic [31:0] testMEM;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    mem_stage_param dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .ALUresultEX(ALUresultEX), .storeDataEX(storeDataEX),
        .writeRegEX(writeRegEX), .rtEX(rtEX), .controlEX(controlEX),
        .accessSize(accessSize), .loadUnsigned(loadUnsigned),
        .data(data), .ALUresultMEM(ALUresultMEM),
        .writeRegMEM(writeRegMEM), .controlMEM(controlMEM),
        .misaligned(misaligned), .outOfRange(outOfRange),
        .testMEM(testMEM)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [10:0] c, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] wr,
                          input logic [4:0] rt, input logic [1:0] sz,
                          input logic uns);
        controlEX    = c;
        ALUresultEX  = a;
        storeDataEX  = sd;
        writeRegEX   = wr;
        rtEX         = rt;
        accessSize   = sz;
        loadUnsigned = uns;
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [1:0] sz,
                              input logic uns, input logic [4:0] wr,
                              input logic [31:0] exp);
        set_in(LD, a, 32'h0, wr, 5'd0, sz, uns);
        exp_q.push_back(exp);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        stall = 1'b0;
        set_in(NOP, 32'h0, 32'h0, 5'd0, 5'd0, 2'b10, 1'b0);
        tick;
        tick;
        checks++;
        if ({data, ALUresultMEM, writeRegMEM, controlMEM,
             misaligned, outOfRange} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h alu=%h wr=%h ctl=%h mis=%b oor=%b required all 0",
                     data, ALUresultMEM, writeRegMEM, controlMEM, misaligned, outOfRange);
        end
        checks++;
        if (testMEM !== 32'h4) begin
            errors++;
            $display("FAIL reset_testmem: got %h required 00000004", testMEM);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_lw;
        issue_load(32'h14, 2'b10, 1'b0, 5'd9, 32'h5);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL lw_0x14: data=%h required %h", data, e);
        end
        checks++;
        if (controlMEM !== LD || writeRegMEM !== 5'd9 || ALUresultMEM !== 32'h14) begin
            errors++;
            $display("FAIL lw_pipe: ctl=%h wr=%0d alu=%h required %h 9 00000014",
                     controlMEM, writeRegMEM, ALUresultMEM, LD);
        end
    endtask

    task automatic test_subword;
        set_in(ST, 32'h09, 32'h123456AB, 5'd0, 5'd3, 2'b00, 1'b0);
        tick;
        issue_load(32'h08, 2'b10, 1'b0, 5'd1, 32'h0000AB02);
        issue_load(32'h09, 2'b00, 1'b0, 5'd1, 32'hFFFFFFAB);
        issue_load(32'h09, 2'b00, 1'b1, 5'd1, 32'h000000AB);
        issue_load(32'h08, 2'b01, 1'b0, 5'd1, 32'hFFFFAB02);
        issue_load(32'h08, 2'b01, 1'b1, 5'd1, 32'h0000AB02);
        for (int i = 0; i < 5; i++) begin
            ALUresultEX  = (i == 0) ? 32'h08 : (i < 3) ? 32'h09 : 32'h08;
            accessSize   = (i == 0) ? 2'b10 : (i < 3) ? 2'b00 : 2'b01;
            loadUnsigned = (i == 2 || i == 4);
            tick;
            e = exp_q.pop_front();
            checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL subword_load_%0d: data=%h required %h", i, data, e);
            end
        end
    endtask

    task automatic test_forward;
        for (int k = 0; k < 2; k++) begin
            issue_load(32'h0C, 2'b10, 1'b0, 5'd8, 32'h3);
            tick;
            e = exp_q.pop_front();
            checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL fwd_lw_%0d: data=%h required %h", k, data, e);
            end
            set_in(ST, 32'h20, 32'h0000DEAD, 5'd0, (k == 0) ? 5'd8 : 5'd0,
                   2'b10, 1'b0);
            tick;
            issue_load(32'h20, 2'b10, 1'b0, 5'd2,
                       (k == 0) ? 32'h3 : 32'h0000DEAD);
            tick;
            e = exp_q.pop_front();
            checks++;
            if (data !== e) begin
                errors++;
                $display("FAIL fwd_mem8_%0d: data=%h required %h", k, data, e);
            end
        end
    endtask

    task automatic test_faults;
        set_in(ST, 32'h06, 32'hFFFFFFFF, 5'd0, 5'd4, 2'b10, 1'b0);
        tick;
        checks++;
        if (misaligned !== 1'b1 || outOfRange !== 1'b0 || data !== 32'h0) begin
            errors++;
            $display("FAIL sw_misaligned: mis=%b oor=%b data=%h required 1 0 0",
                     misaligned, outOfRange, data);
        end
        issue_load(32'h04, 2'b10, 1'b0, 5'd1, 32'h1);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (misaligned !== 1'b0 || data !== e) begin
            errors++;
            $display("FAIL mis_cleared_mem1: mis=%b data=%h required 0 %h",
                     misaligned, data, e);
        end
        issue_load(32'h40, 2'b10, 1'b0, 5'd1, 32'h0);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (outOfRange !== 1'b1 || data !== e) begin
            errors++;
            $display("FAIL lw_oor: oor=%b data=%h required 1 %h", outOfRange, data, e);
        end
        issue_load(32'h0B, 2'b01, 1'b0, 5'd1, 32'h0);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (misaligned !== 1'b1 || outOfRange !== 1'b0 || data !== e) begin
            errors++;
            $display("FAIL lh_misaligned: mis=%b oor=%b data=%h required 1 0 %h",
                     misaligned, outOfRange, data, e);
        end
    endtask

    task automatic test_stall;
        set_in(11'h001, 32'h30, 32'h0, 5'd3, 5'd0, 2'b10, 1'b0);
        tick;
        set_in(ST, 32'h10, 32'h12345678, 5'd0, 5'd0, 2'b10, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (testMEM !== 32'h4 || controlMEM !== 11'h001 ||
                writeRegMEM !== 5'd3 || ALUresultMEM !== 32'h30) begin
                errors++;
                $display("FAIL stall_hold_%0d: mem4=%h ctl=%h wr=%0d alu=%h required 00000004 001 3 00000030",
                         i, testMEM, controlMEM, writeRegMEM, ALUresultMEM);
            end
        end
        stall = 1'b0;
        tick;
        checks++;
        if (testMEM !== 32'h12345678 || controlMEM !== ST) begin
            errors++;
            $display("FAIL stall_release: mem4=%h ctl=%h required 12345678 %h",
                     testMEM, controlMEM, ST);
        end
        issue_load(32'h0C, 2'b10, 1'b0, 5'd5, 32'h3);
        tick;
        void'(exp_q.pop_front());
        set_in(ST, 32'h24, 32'h0000BEEF, 5'd0, 5'd5, 2'b10, 1'b0);
        stall = 1'b1;
        tick;
        tick;
        stall = 1'b0;
        tick;
        issue_load(32'h24, 2'b10, 1'b0, 5'd6, 32'h3);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL stall_fwd_mem9: data=%h required %h", data, e);
        end
    endtask

    task automatic test_async_reset;
        issue_load(32'h10, 2'b10, 1'b0, 5'd7, 32'h12345678);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL pre_reset_lw: data=%h required %h", data, e);
        end
        set_in(ST, 32'h10, 32'hCAFEF00D, 5'd0, 5'd0, 2'b10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (data !== 32'h0 || controlMEM !== 11'h0 || writeRegMEM !== 5'd0 ||
            ALUresultMEM !== 32'h0 || testMEM !== 32'h4) begin
            errors++;
            $display("FAIL async_reset: data=%h ctl=%h wr=%0d alu=%h mem4=%h required 0 0 0 0 00000004",
                     data, controlMEM, writeRegMEM, ALUresultMEM, testMEM);
        end
        tick;
        checks++;
        if (testMEM !== 32'h4) begin
            errors++;
            $display("FAIL reset_mid_store: mem4=%h required 00000004", testMEM);
        end
        set_in(NOP, 32'h0, 32'h0, 5'd0, 5'd0, 2'b10, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        issue_load(32'h08, 2'b10, 1'b0, 5'd1, 32'h2);
        tick;
        e = exp_q.pop_front();
        checks++;
        if (data !== e) begin
            errors++;
            $display("FAIL post_reset_mem2: data=%h required %h", data, e);
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_subword;
        test_forward;
        test_faults;
        test_stall;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_param.md
MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, meaning data/address width; multiple of 32.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning data-memory words; power of 2, ≥2.
REQ-003 The block SHALL have parameter CTRL_W, default 11, meaning control vector width.
REQ-004 The block SHALL have parameter RD_BIT, default 6, meaning memRead bit index in control.
REQ-005 The block SHALL have parameter WR_BIT, default 8, meaning memWrite bit index in control.
REQ-006 The block SHALL have parameter TEST_ADDR, default 4, meaning word index driven on testMEM.
REQ-007 The block SHALL have port clk  in  1  pipeline clock, rising edge; one clock only.
REQ-008 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-009 The block SHALL have port stall  in  1  hold stage; suppress memory write.
REQ-010 The block SHALL have port ALUresultEX  in  SIZE  byte address from EX.
REQ-011 The block SHALL have port storeDataEX  in  SIZE  store data from EX.
REQ-012 The block SHALL have port writeRegEX  in  5  destination register of EX instruction.
REQ-013 The block SHALL have port rtEX  in  5  store-source register of EX instruction.
REQ-014 The block SHALL have port controlEX  in  CTRL_W  control of EX instruction.
REQ-015 The block SHALL have port accessSize  in  2  00 byte, 01 half, 10 word (SIZE bits); 11 treated as word.
REQ-016 The block SHALL have port loadUnsigned  in  1  zero-extend sub-word loads.
REQ-017 The block SHALL have port data  out  SIZE  registered load result.
REQ-018 The block SHALL have port ALUresultMEM  out  SIZE  registered address/ALU pass-through.
REQ-019 The block SHALL have port writeRegMEM  out  5  registered destination register.
REQ-020 The block SHALL have port controlMEM  out  CTRL_W  registered control.
REQ-021 The block SHALL have port misaligned  out  1  registered fault flag.
REQ-022 The block SHALL have port outOfRange  out  1  registered fault flag.
REQ-023 The block SHALL have port testMEM  out  SIZE  combinational view of mem[TEST_ADDR].

Function
REQ-024 The block SHALL decode address fields as BL=$clog2(SIZE/8), word index = ALUresultEX[SIZE-1:BL], byte lane = ALUresultEX[BL-1:0], little-endian lanes.
REQ-025 The block SHALL flag misaligned for a memory access when half has lane bit0=1 or word has lane≠0.
REQ-026 The block SHALL flag outOfRange for a memory access when word index ≥ DEPTH.
REQ-027 The block SHALL suppress the access on any fault: no write, data=0, and the flag registered for one cycle with the instruction.
REQ-028 The block SHALL, when controlEX[RD_BIT]=1, register on the next rising edge data = the selected byte/half/word right-aligned, sign-extended unless loadUnsigned=1 (word: no extension); latency 1 cycle.
REQ-029 The block SHALL, when controlEX[RD_BIT]=0, hold data at its previous value.
REQ-030 The block SHALL, when controlEX[WR_BIT]=1, write only the addressed byte lanes at the rising edge, leaving the other lanes unchanged.
REQ-031 The block SHALL, on load-to-store forwarding (controlMEM[RD_BIT]=1, controlEX[WR_BIT]=1, writeRegMEM==rtEX, rtEX≠0), use data as store data instead of storeDataEX.
REQ-032 The block SHALL make a store visible to a load in the following cycle (no stale read); controlEX RD and WR both set is illegal and SHALL be treated as store only.
REQ-033 The block SHALL, when stall=1, hold all output registers and write nothing; when stall=0, update controlMEM, writeRegMEM and ALUresultMEM every cycle.
REQ-034 The block SHALL forward on stall release using held controlMEM/writeRegMEM/data.

Reset
REQ-035 The block SHALL, while rst_n=0 (asynchronously, overriding stall), clear data, ALUresultMEM, controlMEM, misaligned and outOfRange to 0, set writeRegMEM=0, and set mem[i]=i for every i.
REQ-036 The block SHALL, on rst_n deassertion, resume on the first rising edge with rst_n=1; a reset mid-store leaves memory at reset values.

Verification
REQ-037 The bench SHALL cover: reset; lw from 0x14 -> data=0x00000005 after 1 edge, controlMEM/writeRegMEM follow EX.
REQ-038 The bench SHALL cover: sb 0x...AB at 0x09 -> mem[2]=0x0000AB02; lb at 0x09 -> 0xFFFFFFAB; lbu -> 0x000000AB.
REQ-039 The bench SHALL cover: lw $8 from 0x0C then sw rtEX=8, storeDataEX=0xDEAD to 0x20 -> mem[8]=0x00000003; same with rtEX=0 -> mem[8]=0x0000DEAD.
REQ-040 The bench SHALL cover: sw word at 0x06 -> mem unchanged, misaligned=1 one cycle; lw at 0x40 (DEPTH=16) -> outOfRange=1, data=0.
REQ-041 The bench SHALL cover: sw 0x12345678 to 0x10 with stall=1 for 3 cycles -> mem[4]/testMEM stays 0x00000004, outputs frozen; stall=0 -> testMEM=0x12345678.
REQ-042 The bench SHALL cover: rst_n pulsed low between edges after writes -> outputs 0 immediately, testMEM=0x00000004 without a clock edge.
